// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/subtract unit whose carry chain is cut into
// STAGES equal segments with one register stage per segment. Each stage
// register carries one vector that holds the finished lower sum segments in
// its low bits and the not-yet-added operand A bits in its high bits, plus the
// effective B operand, the segment carry and the beat valid bit. A single
// global enable (advance) freezes every stage while the sink stalls.

module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One carry segment: SEG-bit add with carry-in, result carries out in MSB.
  function automatic logic [SEG:0] seg_add(input logic [SEG-1:0] a,
                                           input logic [SEG-1:0] b,
                                           input logic           c);
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, c};
  endfunction

  // Stage registers (index k = output of stage k; LAST drives the outputs).
  logic [STAGES-1:0] vld_r;
  logic [STAGES-1:0] carry_r;
  logic [WIDTH-1:0]  acc_r  [STAGES];
  logic [WIDTH-1:0]  beff_r [STAGES];
  logic              ovf_r;

  // Combinational stage inputs and next values.
  logic              advance_s;
  logic [WIDTH-1:0]  acc_in_s  [STAGES];
  logic [WIDTH-1:0]  beff_in_s [STAGES];
  logic [WIDTH-1:0]  acc_nxt_s [STAGES];
  logic [STAGES-1:0] cin_s;
  logic [STAGES-1:0] vin_s;
  logic [STAGES-1:0] cout_s;
  logic              ovf_nxt_s;
  logic [SEG:0]      seg_s;

  // Whole pipeline moves only when the output slot is free or being drained.
  always_comb begin
    advance_s = ~vld_r[LAST] | out_ready;
  end

  // Route each stage's inputs: stage 0 takes the prepared operands, later
  // stages take the previous stage's registers.
  always_comb begin
    cin_s        = '0;
    vin_s        = '0;
    acc_in_s[0]  = in_a;
    beff_in_s[0] = in_b;
    if (in_sub) begin
      beff_in_s[0] = ~in_b;
      cin_s[0]     = 1'b1;
    end else begin
      beff_in_s[0] = in_b;
      cin_s[0]     = in_cin;
    end
    vin_s[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      acc_in_s[k]  = acc_r[k-1];
      beff_in_s[k] = beff_r[k-1];
      cin_s[k]     = carry_r[k-1];
      vin_s[k]     = vld_r[k-1];
    end
  end

  // Add segment k in stage k and splice its sum into the travelling vector;
  // overflow is carry-into-MSB XOR carry-out, taken from the last segment.
  always_comb begin
    seg_s  = '0;
    cout_s = '0;
    for (int k = 0; k < STAGES; k++) begin
      acc_nxt_s[k] = acc_in_s[k];
      seg_s = seg_add(acc_in_s[k][k*SEG +: SEG], beff_in_s[k][k*SEG +: SEG], cin_s[k]);
      acc_nxt_s[k][k*SEG +: SEG] = seg_s[SEG-1:0];
      cout_s[k] = seg_s[SEG];
    end
    ovf_nxt_s = acc_in_s[LAST][WIDTH-1] ^ beff_in_s[LAST][WIDTH-1]
              ^ acc_nxt_s[LAST][WIDTH-1] ^ cout_s[LAST];
  end

  // Stage registers: clear on reset, advance together, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r   <= '0;
      carry_r <= '0;
      ovf_r   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        acc_r[k]  <= '0;
        beff_r[k] <= '0;
      end
    end else if (advance_s) begin
      vld_r   <= vin_s;
      carry_r <= cout_s;
      ovf_r   <= ovf_nxt_s;
      for (int k = 0; k < STAGES; k++) begin
        acc_r[k]  <= acc_nxt_s[k];
        beff_r[k] <= beff_in_s[k];
      end
    end
  end

  assign in_ready  = advance_s & ~rst;
  assign out_valid = vld_r[LAST];
  assign out_sum   = acc_r[LAST];
  assign out_cout  = carry_r[LAST];
  assign out_ovf   = ovf_r;

endmodule
